// File: rtl/touch_pkg.sv
// rtl/touch_pkg.sv - shared command codes, frame geometry and sequencer state type
package touch_pkg;

  localparam logic [7:0] CMD_X = 8'hD0;
  localparam logic [7:0] CMD_Y = 8'h90;

  localparam int FRAME_BITS = 24;
  localparam int DATA_FIRST = 10;
  localparam int DATA_BITS  = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEB_DN,
    ST_FRAME_X,
    ST_FRAME_Y,
    ST_SETTLE,
    ST_GAP,
    ST_DEB_UP
  } seq_state_e;

  function automatic logic [7:0] coord_of(input logic [DATA_BITS-1:0] res);
    return res[DATA_BITS-1 -: 8];
  endfunction

endpackage

// File: rtl/touch_adc_spi.sv
// rtl/touch_adc_spi.sv - one 24-DCLK command/response frame on the panel ADC serial link
module touch_adc_spi
  import touch_pkg::*;
#(
  parameter int CLK_DIV = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [7:0]           cmd_i,
  input  logic                 miso_i,
  output logic                 cs_n_o,
  output logic                 dclk_o,
  output logic                 mosi_o,
  output logic                 done_o,
  output logic [DATA_BITS-1:0] result_o
);

  localparam int            DW        = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [5:0]    LAST_TICK = 6'(2 * FRAME_BITS - 1);
  localparam logic [5:0]    DATA_LO   = 6'(DATA_FIRST);
  localparam logic [5:0]    DATA_HI   = 6'(DATA_FIRST + DATA_BITS - 1);

  logic                 active_q, active_d;
  logic                 tail_q, tail_d;
  logic                 cs_n_q, cs_n_d;
  logic                 dclk_q, dclk_d;
  logic                 mosi_q, mosi_d;
  logic [DW-1:0]        div_q, div_d;
  logic [5:0]           tick_cnt_q, tick_cnt_d;
  logic [7:0]           cmd_q, cmd_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;

  logic       tick;
  logic       sample;
  logic [5:0] rise_n;

  // tick_cnt_q is even before every rising tick, so half of it numbers the DCLK period
  assign tick   = active_q && !tail_q && (div_q == DIV_LAST);
  assign rise_n = {1'b0, tick_cnt_q[5:1]} + 6'd1;
  assign sample = !dclk_q && (rise_n >= DATA_LO) && (rise_n <= DATA_HI);

  always_comb begin
    active_d   = active_q;
    tail_d     = tail_q;
    cs_n_d     = cs_n_q;
    dclk_d     = dclk_q;
    mosi_d     = mosi_q;
    div_d      = div_q;
    tick_cnt_d = tick_cnt_q;
    cmd_d      = cmd_q;
    shift_d    = shift_q;
    if (!active_q) begin
      if (start_i) begin
        active_d   = 1'b1;
        cs_n_d     = 1'b0;
        mosi_d     = cmd_i[7];
        cmd_d      = {cmd_i[6:0], 1'b0};
        div_d      = '0;
        tick_cnt_d = '0;
        shift_d    = '0;
      end
    end else if (tail_q) begin
      // one extra cycle after the last falling tick before chip select releases
      active_d = 1'b0;
      tail_d   = 1'b0;
      cs_n_d   = 1'b1;
      dclk_d   = 1'b0;
      mosi_d   = 1'b0;
    end else begin
      div_d = tick ? '0 : div_q + DW'(1);
      if (tick) begin
        dclk_d     = ~dclk_q;
        tick_cnt_d = tick_cnt_q + 6'd1;
        if (!dclk_q) begin
          if (sample) shift_d = {shift_q[DATA_BITS-2:0], miso_i};
        end else begin
          mosi_d = cmd_q[7];
          cmd_d  = {cmd_q[6:0], 1'b0};
        end
        if (tick_cnt_q == LAST_TICK) tail_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q   <= 1'b0;
      tail_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      dclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      div_q      <= '0;
      tick_cnt_q <= '0;
      cmd_q      <= '0;
      shift_q    <= '0;
    end else begin
      active_q   <= active_d;
      tail_q     <= tail_d;
      cs_n_q     <= cs_n_d;
      dclk_q     <= dclk_d;
      mosi_q     <= mosi_d;
      div_q      <= div_d;
      tick_cnt_q <= tick_cnt_d;
      cmd_q      <= cmd_d;
      shift_q    <= shift_d;
    end
  end

  assign cs_n_o   = cs_n_q;
  assign dclk_o   = dclk_q;
  assign mosi_o   = mosi_q;
  assign done_o   = tail_q;
  assign result_o = shift_q;

endmodule

// File: rtl/touch_adc_seq.sv
// rtl/touch_adc_seq.sv - pen debounce and X/Y conversion sequencer for the resistive touch ADC
module touch_adc_seq
  import touch_pkg::*;
#(
  parameter int CLK_DIV    = 32,
  parameter int DEBOUNCE   = 1024,
  parameter int SETTLE     = 256,
  parameter int SAMPLE_GAP = 4096
) (
  input  logic       sys_clk,
  input  logic       iRST_n,
  input  logic       penirq_n,
  input  logic       adc_dout,
  output logic       adc_cs_n,
  output logic       adc_dclk,
  output logic       adc_din,
  output logic [7:0] x,
  output logic [7:0] y,
  output logic       new_coord_r,
  output logic       transmit_en,
  output logic       busy
);

  localparam int MAX_A = (DEBOUNCE > SETTLE) ? DEBOUNCE : SETTLE;
  localparam int MAX_C = (MAX_A > SAMPLE_GAP) ? MAX_A : SAMPLE_GAP;
  localparam int CW    = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] DEB_LAST    = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'(SAMPLE_GAP - 1);

  seq_state_e           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [1:0]           sync_q;
  logic                 start_q, start_d;
  logic                 tx_en_q, tx_en_d;
  logic                 strobe_q, strobe_d;
  logic [7:0]           x_q, x_d, y_q, y_d;
  logic [7:0]           xr_q, xr_d, yr_q, yr_d;
  logic                 pen_dn;
  logic                 spi_cs_n;
  logic                 spi_done;
  logic [DATA_BITS-1:0] spi_result;
  logic                 unused_lsb;

  touch_adc_spi #(.CLK_DIV(CLK_DIV)) u_spi (
    .clk_i    (sys_clk),
    .rst_ni   (iRST_n),
    .start_i  (start_q),
    .cmd_i    ((state_q == ST_FRAME_Y) ? CMD_Y : CMD_X),
    .miso_i   (adc_dout),
    .cs_n_o   (spi_cs_n),
    .dclk_o   (adc_dclk),
    .mosi_o   (adc_din),
    .done_o   (spi_done),
    .result_o (spi_result)
  );

  assign unused_lsb = ^spi_result[3:0];

  always_ff @(posedge sys_clk or negedge iRST_n) begin
    if (!iRST_n) sync_q <= 2'b11;
    else         sync_q <= {sync_q[0], penirq_n};
  end

  // the FSM only looks at the pen outside frame states, which masks ADC-induced noise
  assign pen_dn = ~sync_q[1];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    start_d  = 1'b0;
    tx_en_d  = tx_en_q;
    strobe_d = 1'b0;
    x_d      = x_q;
    y_d      = y_q;
    xr_d     = xr_q;
    yr_d     = yr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pen_dn) begin
          state_d = ST_DEB_DN;
          cnt_d   = '0;
        end
      end
      ST_DEB_DN: begin
        if (!pen_dn) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = ST_FRAME_X;
          start_d = 1'b1;
          tx_en_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_FRAME_X: begin
        if (spi_done) begin
          xr_d    = coord_of(spi_result);
          state_d = ST_FRAME_Y;
          start_d = 1'b1;
        end
      end
      ST_FRAME_Y: begin
        if (spi_done) begin
          yr_d    = coord_of(spi_result);
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d = '0;
          if (pen_dn) begin
            x_d      = xr_q;
            y_d      = yr_q;
            strobe_d = 1'b1;
            state_d  = ST_GAP;
          end else begin
            state_d = ST_DEB_UP;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_GAP: begin
        if (!pen_dn) begin
          state_d = ST_DEB_UP;
          cnt_d   = '0;
        end else if (cnt_q == GAP_LAST) begin
          state_d = ST_FRAME_X;
          start_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DEB_UP: begin
        if (pen_dn) begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = ST_IDLE;
          tx_en_d = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      start_q  <= 1'b0;
      tx_en_q  <= 1'b0;
      strobe_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      xr_q     <= '0;
      yr_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      start_q  <= start_d;
      tx_en_q  <= tx_en_d;
      strobe_q <= strobe_d;
      x_q      <= x_d;
      y_q      <= y_d;
      xr_q     <= xr_d;
      yr_q     <= yr_d;
    end
  end

  assign adc_cs_n    = spi_cs_n;
  assign busy        = ~spi_cs_n;
  assign x           = x_q;
  assign y           = y_q;
  assign new_coord_r = strobe_q;
  assign transmit_en = tx_en_q;

endmodule

// File: tb/tb_touch_adc_seq.sv
// tb/tb_touch_adc_seq.sv - self-checking bench for touch_adc_seq with a behavioural panel ADC
module tb_touch_adc_seq;

  localparam int C         = 2;
  localparam int DEB       = 8;
  localparam int SET       = 16;
  localparam int GAPC      = 32;
  localparam int FRAME_LEN = 48 * C + 1;
  localparam int SPACING   = 2 * FRAME_LEN + SET + GAPC + 2;
  localparam int NVEC      = 5;

  logic       sys_clk  = 1'b0;
  logic       iRST_n   = 1'b0;
  logic       penirq_n = 1'b0;
  logic       adc_dout = 1'b0;
  logic       adc_cs_n, adc_dclk, adc_din;
  logic [7:0] x, y;
  logic       new_coord_r, transmit_en, busy;

  touch_adc_seq #(
    .CLK_DIV(C), .DEBOUNCE(DEB), .SETTLE(SET), .SAMPLE_GAP(GAPC)
  ) dut (
    .sys_clk     (sys_clk),
    .iRST_n      (iRST_n),
    .penirq_n    (penirq_n),
    .adc_dout    (adc_dout),
    .adc_cs_n    (adc_cs_n),
    .adc_dclk    (adc_dclk),
    .adc_din     (adc_din),
    .x           (x),
    .y           (y),
    .new_coord_r (new_coord_r),
    .transmit_en (transmit_en),
    .busy        (busy)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [11:0] adc_x;
    logic [11:0] adc_y;
    logic [7:0]  exp_x;
    logic [7:0]  exp_y;
  } vec_t;

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
  } exp_t;

  vec_t vecs [NVEC];
  exp_t sb_q [$];

  int checks = 0, errors = 0;
  int cyc = 0, cs_falls = 0, strobes = 0, fticks = 0, t_fall = 0, tx_drops = 0;
  int mdl_rise = 0, mdl_next = 0;
  logic mon_en = 1'b0, tx_watch = 1'b0;
  logic prev_cs = 1'b1, prev_dclk = 1'b0, prev_strobe = 1'b0;
  logic [7:0]  px = 8'h00, py = 8'h00, exp_cmd = 8'hD0, mdl_cmd = 8'h00;
  logic [11:0] mdl_x = 12'h000, mdl_y = 12'h000, mdl_val = 12'h000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge sys_clk) cyc++;

  // Panel ADC model plus per-frame checks of length, tick count and command byte
  always @(adc_cs_n or adc_dclk) begin
    if (adc_cs_n === 1'b0 && prev_cs === 1'b1) begin
      t_fall   = cyc;
      fticks   = 0;
      mdl_rise = 0;
      mdl_cmd  = 8'h00;
      mdl_val  = 12'h000;
      adc_dout = 1'b0;
      cs_falls++;
    end else if (adc_cs_n === 1'b1 && prev_cs === 1'b0) begin
      if (iRST_n) begin
        chk("frame_ticks", 32'(fticks), 32'd48);
        chk("frame_len", 32'(cyc - t_fall), 32'(FRAME_LEN));
        chk("frame_cmd", 32'(mdl_cmd), 32'(exp_cmd));
        exp_cmd = (exp_cmd == 8'hD0) ? 8'h90 : 8'hD0;
      end
    end else if (adc_cs_n === 1'b0 && adc_dclk !== prev_dclk) begin
      fticks++;
      if (adc_dclk) begin
        mdl_rise++;
        if (mdl_rise <= 8) mdl_cmd = {mdl_cmd[6:0], adc_din};
        if (mdl_rise == 8) mdl_val = (mdl_cmd == 8'hD0) ? mdl_x : mdl_y;
        mdl_next = mdl_rise + 1;
        adc_dout = (mdl_next >= 10 && mdl_next <= 21) ? mdl_val[21 - mdl_next] : 1'b0;
      end
    end
    prev_cs   = adc_cs_n;
    prev_dclk = adc_dclk;
  end

  // Scoreboard: every strobe pops one expected pair; x/y may only move with a strobe
  always @(negedge sys_clk) begin
    if (mon_en) begin
      if (new_coord_r) begin
        strobes++;
        chk("strobe_width", 32'(prev_strobe), 32'd0);
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got x=%0h y=%0h expected no strobe", x, y);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("coord_x", 32'(x), 32'(e.x));
          chk("coord_y", 32'(y), 32'(e.y));
        end
      end else if (x !== px || y !== py) begin
        chk("xy_hold", {16'h0, x, y}, {16'h0, px, py});
      end
      if (tx_watch && !transmit_en) tx_drops++;
    end
    px          = x;
    py          = y;
    prev_strobe = new_coord_r;
  end

  initial begin
    int n, f0, s0, last_c;
    bit found;

    vecs[0] = '{12'hA5F, 12'h3C1, 8'hA5, 8'h3C};
    vecs[1] = '{12'h000, 12'hFFF, 8'h00, 8'hFF};
    vecs[2] = '{12'hFFF, 12'h000, 8'hFF, 8'h00};
    vecs[3] = '{12'h00F, 12'hFF0, 8'h00, 8'hFF};
    vecs[4] = '{12'h810, 12'h7EF, 8'h81, 8'h7E};

    mdl_x = vecs[0].adc_x;
    mdl_y = vecs[0].adc_y;
    sb_q.push_back('{vecs[0].exp_x, vecs[0].exp_y});

    // Reset held with the pen already down
    repeat (3) @(negedge sys_clk);
    chk("rst_cs_n", 32'(adc_cs_n), 32'd1);
    chk("rst_dclk", 32'(adc_dclk), 32'd0);
    chk("rst_din", 32'(adc_din), 32'd0);
    chk("rst_x", 32'(x), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_strobe", 32'(new_coord_r), 32'd0);
    chk("rst_tx_en", 32'(transmit_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    iRST_n = 1'b1;
    mon_en = 1'b1;
    n = 0;
    while (!transmit_en && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    chk("tx_latency", 32'(n), 32'(DEB + 3));
    chk("cs_after_tx", 32'(adc_cs_n), 32'd1);
    @(negedge sys_clk);
    chk("busy_in_frame", 32'(busy), 32'd1);
    tx_watch = 1'b1;

    // Pen held: one strobe per table entry at a fixed spacing
    last_c = 0;
    for (int i = 0; i < NVEC; i++) begin
      found = 1'b0;
      for (int k = 0; k < 1000 && !found; k++) begin
        @(negedge sys_clk);
        if (new_coord_r) found = 1'b1;
      end
      chk("strobe_seen", 32'(found), 32'd1);
      if (i > 0) chk("strobe_spacing", 32'(cyc - last_c), 32'(SPACING));
      last_c = cyc;
      if (i + 1 < NVEC) begin
        mdl_x = vecs[i+1].adc_x;
        mdl_y = vecs[i+1].adc_y;
        sb_q.push_back('{vecs[i+1].exp_x, vecs[i+1].exp_y});
      end
    end
    tx_watch = 1'b0;
    chk("tx_continuous", 32'(tx_drops), 32'd0);

    // Pen lifted during the Y frame: pair discarded, session closes after settle+debounce
    f0 = cs_falls;
    for (int k = 0; k < 1000 && cs_falls < f0 + 2; k++) @(negedge sys_clk);
    chk("reach_frame_y", 32'(cs_falls), 32'(f0 + 2));
    penirq_n = 1'b1;
    s0 = strobes;
    for (int k = 0; k < 1000 && adc_cs_n !== 1'b1; k++) @(negedge sys_clk);
    n = 1;
    while (transmit_en && n < 1000) begin
      @(negedge sys_clk);
      n++;
    end
    chk("tx_fall_delay", 32'(n), 32'(SET + DEB + 1));
    chk("no_strobe_on_lift", 32'(strobes), 32'(s0));

    // Short pen glitch must not open a session
    f0 = cs_falls;
    penirq_n = 1'b0;
    repeat (5) @(negedge sys_clk);
    penirq_n = 1'b1;
    repeat (40) @(negedge sys_clk);
    chk("glitch_tx_en", 32'(transmit_en), 32'd0);
    chk("glitch_no_frame", 32'(cs_falls), 32'(f0));

    // Reset pulse in the middle of an X frame
    s0 = strobes;
    f0 = cs_falls;
    penirq_n = 1'b0;
    for (int k = 0; k < 500 && cs_falls == f0; k++) @(negedge sys_clk);
    for (int k = 0; k < 200 && fticks < 20; k++) @(negedge sys_clk);
    chk("abort_tick", 32'(fticks), 32'd20);
    chk("busy_pre_abort", 32'(busy), 32'd1);
    mon_en = 1'b0;
    iRST_n = 1'b0;
    #1;
    chk("abort_cs_n", 32'(adc_cs_n), 32'd1);
    chk("abort_dclk", 32'(adc_dclk), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge sys_clk);
    chk("abort_x", 32'(x), 32'd0);
    chk("abort_y", 32'(y), 32'd0);
    chk("abort_strobe", 32'(new_coord_r), 32'd0);
    chk("abort_tx_en", 32'(transmit_en), 32'd0);
    penirq_n = 1'b1;
    iRST_n   = 1'b1;
    repeat (3) @(negedge sys_clk);
    mon_en = 1'b1;
    f0 = cs_falls;
    repeat (50) @(negedge sys_clk);
    chk("post_abort_idle", 32'(cs_falls), 32'(f0));
    chk("post_abort_x", 32'(x), 32'd0);
    chk("post_abort_strobes", 32'(strobes), 32'(s0));
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
